// File: rtl/usb_cmd_pkg.sv
// Shared constants, FSM state encoding and configuration record for the USB command controller.
package usb_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] OP_STATE    = 8'h01;
  localparam logic [7:0] OP_FREQ     = 8'h02;
  localparam logic [7:0] OP_AMP      = 8'h03;
  localparam logic [7:0] OP_PHASE    = 8'h04;
  localparam logic [7:0] OP_COMMIT   = 8'h05;
  localparam logic [7:0] OP_DEFAULTS = 8'h06;

  localparam logic [7:0] RSP_ACK     = 8'h06;
  localparam logic [7:0] NAK_CHK     = 8'h15;
  localparam logic [7:0] NAK_ARG     = 8'h1A;

  typedef enum logic [2:0] {
    IDLE, GET_OP, GET_D1, GET_D0, GET_CHK, EXEC, RESP
  } fsm_t;

  typedef struct packed {
    logic [4:0]  state;
    logic [11:0] freq;
    logic [2:0]  amp;
    logic [7:0]  phase;
  } cfg_t;

endpackage

// File: rtl/usb_cmd_timeout.sv
// Inter-byte gap counter: counts while enabled, expires after TIMEOUT_CYC cycles without a clear.
// o_expire is combinational and lands on the edge that completes the TIMEOUT_CYC-th idle cycle.
module usb_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [W-1:0] r_cnt;

  assign o_expire = i_en && !i_clr && (r_cnt == W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_expire) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/usb_cmd_ctrl.sv
// Frames 5-byte host commands into shadow config, commits atomically, answers with ACK/NAK.
// Result appears one cycle after the CHK byte; rx is back-pressured until the response is taken.
module usb_cmd_ctrl
  import usb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [4:0]  DEF_STATE   = 5'd0,
  parameter logic [11:0] DEF_FREQ    = 12'd1,
  parameter logic [2:0]  DEF_AMP     = 3'd7,
  parameter logic [7:0]  DEF_PHASE   = 8'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [4:0]  o_state,
  output logic [11:0] o_state_freq,
  output logic [2:0]  o_state_amp,
  output logic [7:0]  o_state_phase,
  output logic        o_cfg_upd,
  output logic [7:0]  o_err_cnt
);

  localparam cfg_t DEF_CFG = {DEF_STATE, DEF_FREQ, DEF_AMP, DEF_PHASE};

  fsm_t       r_fsm, w_fsm_nxt;
  cfg_t       r_shadow, r_active, w_shadow_nxt, w_active_nxt;
  logic [7:0] r_op, r_d1, r_d0, r_chk;
  logic [7:0] r_tx_data, w_tx_dat_nxt, r_err_cnt;
  logic       r_tx_valid, w_tx_vld_nxt, r_cfg_upd, w_upd, w_err_inc, w_nak_arg;
  logic       w_in_get, w_acc, w_expire;

  assign w_in_get   = r_fsm inside {GET_OP, GET_D1, GET_D0, GET_CHK};
  assign o_rx_ready = i_rst_n && (w_in_get || r_fsm == IDLE);
  assign w_acc      = i_rx_valid && o_rx_ready;

  usb_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_acc || !w_in_get),
    .i_en     (w_in_get),
    .o_expire (w_expire)
  );

  always_comb begin
    w_fsm_nxt    = r_fsm;
    w_shadow_nxt = r_shadow;
    w_active_nxt = r_active;
    w_tx_dat_nxt = r_tx_data;
    w_tx_vld_nxt = r_tx_valid;
    w_upd        = 1'b0;
    w_err_inc    = 1'b0;
    w_nak_arg    = 1'b0;
    case (r_fsm)
      IDLE:    if (w_acc && i_rx_data == SYNC_BYTE) w_fsm_nxt = GET_OP;
      GET_OP, GET_D1, GET_D0, GET_CHK: begin
        if (w_expire) begin
          w_fsm_nxt = IDLE;
          w_err_inc = 1'b1;
        end else if (w_acc) begin
          w_fsm_nxt = fsm_t'(r_fsm + 3'd1);
        end
      end
      EXEC: begin
        w_fsm_nxt    = RESP;
        w_tx_vld_nxt = 1'b1;
        w_tx_dat_nxt = RSP_ACK;
        if (r_chk != (r_op ^ r_d1 ^ r_d0)) begin
          w_tx_dat_nxt = NAK_CHK;
          w_err_inc    = 1'b1;
        end else begin
          case (r_op)
            OP_STATE:  if (r_d0[7:5] == 3'd0) w_shadow_nxt.state = r_d0[4:0]; else w_nak_arg = 1'b1;
            OP_FREQ:   if (r_d1[7:4] == 4'd0) w_shadow_nxt.freq = {r_d1[3:0], r_d0}; else w_nak_arg = 1'b1;
            OP_AMP:    if (r_d0[7:3] == 5'd0) w_shadow_nxt.amp = r_d0[2:0]; else w_nak_arg = 1'b1;
            OP_PHASE:  w_shadow_nxt.phase = r_d0;
            OP_COMMIT: begin
              w_active_nxt = r_shadow;
              w_upd        = 1'b1;
            end
            OP_DEFAULTS: begin
              w_shadow_nxt = DEF_CFG;
              w_active_nxt = DEF_CFG;
              w_upd        = 1'b1;
            end
            default:   w_nak_arg = 1'b1;
          endcase
          if (w_nak_arg) begin
            w_shadow_nxt = r_shadow;
            w_tx_dat_nxt = NAK_ARG;
            w_err_inc    = 1'b1;
          end
        end
      end
      RESP: begin
        if (i_tx_ready) begin
          w_fsm_nxt    = IDLE;
          w_tx_vld_nxt = 1'b0;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_fsm <= IDLE;
    else          r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow   <= DEF_CFG;
      r_active   <= DEF_CFG;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_cfg_upd  <= 1'b0;
      r_err_cnt  <= 8'h00;
      r_op       <= 8'h00;
      r_d1       <= 8'h00;
      r_d0       <= 8'h00;
      r_chk      <= 8'h00;
    end else begin
      r_shadow   <= w_shadow_nxt;
      r_active   <= w_active_nxt;
      r_tx_data  <= w_tx_dat_nxt;
      r_tx_valid <= w_tx_vld_nxt;
      r_cfg_upd  <= w_upd;
      if (w_err_inc && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_acc) begin
        case (r_fsm)
          GET_OP:  r_op  <= i_rx_data;
          GET_D1:  r_d1  <= i_rx_data;
          GET_D0:  r_d0  <= i_rx_data;
          GET_CHK: r_chk <= i_rx_data;
          default: ;
        endcase
      end
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_valid    = r_tx_valid;
  assign o_cfg_upd     = r_cfg_upd;
  assign o_err_cnt     = r_err_cnt;
  assign o_state       = r_active.state;
  assign o_state_freq  = r_active.freq;
  assign o_state_amp   = r_active.amp;
  assign o_state_phase = r_active.phase;

endmodule

// File: tb/tb_usb_cmd_ctrl.sv
// Directed bench for usb_cmd_ctrl: framing, staging/commit, NAKs, timeout, back-pressure, reset.
module tb_usb_cmd_ctrl;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  state;
  logic [11:0] freq;
  logic [2:0]  amp;
  logic [7:0]  phase;
  logic        cfg_upd;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  usb_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_state(state), .o_state_freq(freq), .o_state_amp(amp), .o_state_phase(phase),
    .o_cfg_upd(cfg_upd), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready byte=%02h rx_ready=%b want 1", b, rx_ready);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [7:0] d1,
                          input logic [7:0] d0, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(d1);
    send_byte(d0);
    send_byte(chk);
  endtask

  // Waits for tx_valid, captures the response, then (tx_ready high) steps one edge.
  task automatic wait_resp(output logic got, output logic [7:0] dat, output logic upd,
                           output logic vld_after, output logic upd_after);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_valid) begin
        got = 1'b1;
        break;
      end
    end
    dat = tx_data;
    upd = cfg_upd;
    tick();
    vld_after = tx_valid;
    upd_after = cfg_upd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'hA5; tx_ready = 1'b1;
    tick(); tick();
    total++;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%b want 0", rx_ready); end
    rx_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    total++;
    if ({state, freq, amp, phase} !== {5'd0, 12'd1, 3'd7, 8'd0}) begin
      bad++; $display("FAIL reset_cfg got=%0d/%0h/%0d/%0h want 0/1/7/0", state, freq, amp, phase);
    end
    total++;
    if ({err_cnt, rx_ready, tx_valid, cfg_upd, tx_data} !== {8'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++; $display("FAIL reset_ctl got err=%0d rdy=%b vld=%b upd=%b txd=%02h want 0 1 0 0 00",
                      err_cnt, rx_ready, tx_valid, cfg_upd, tx_data);
    end
  endtask

  task automatic test_stage_commit();
    logic got, upd, va, ua;
    logic [7:0] d;
    send_pkt(8'h02, 8'h03, 8'hE8, 8'hE9);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({got, d, upd} !== {1'b1, 8'h06, 1'b0}) begin
      bad++; $display("FAIL freq_stage_ack got=%b %02h upd=%b want 1 06 0", got, d, upd);
    end
    total++;
    if (freq !== 12'd1) begin bad++; $display("FAIL freq_staged_only got=%h want 001", freq); end
    total++;
    if (va !== 1'b0) begin bad++; $display("FAIL tx_drop got=%b want 0", va); end
    send_pkt(8'h05, 8'h00, 8'h00, 8'h05);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({got, d, upd} !== {1'b1, 8'h06, 1'b1}) begin
      bad++; $display("FAIL commit_ack got=%b %02h upd=%b want 1 06 1", got, d, upd);
    end
    total++;
    if ({ua, freq} !== {1'b0, 12'h3E8}) begin
      bad++; $display("FAIL commit_freq got upd_after=%b freq=%h want 0 3e8", ua, freq);
    end
  endtask

  task automatic test_nak();
    logic got, upd, va, ua;
    logic [7:0] d;
    send_pkt(8'h03, 8'h00, 8'h09, 8'h0A);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({got, d, err_cnt} !== {1'b1, 8'h1A, 8'd1}) begin
      bad++; $display("FAIL nak_arg got=%b %02h err=%0d want 1 1a 1", got, d, err_cnt);
    end
    send_pkt(8'h04, 8'h00, 8'h80, 8'h00);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({got, d, err_cnt} !== {1'b1, 8'h15, 8'd2}) begin
      bad++; $display("FAIL nak_chk got=%b %02h err=%0d want 1 15 2", got, d, err_cnt);
    end
    send_pkt(8'h05, 8'h00, 8'h00, 8'h05);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({amp, phase, freq} !== {3'd7, 8'h00, 12'h3E8}) begin
      bad++; $display("FAIL nak_no_change got amp=%0d ph=%h fr=%h want 7 00 3e8", amp, phase, freq);
    end
  endtask

  task automatic test_garbage_defaults();
    logic got, upd, va, ua;
    logic [7:0] d;
    send_byte(8'h11);
    send_byte(8'h22);
    send_pkt(8'h04, 8'h00, 8'h40, 8'h44);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({got, d, phase} !== {1'b1, 8'h06, 8'h00}) begin
      bad++; $display("FAIL garbage_ack got=%b %02h ph=%h want 1 06 00", got, d, phase);
    end
    send_pkt(8'h05, 8'h00, 8'h00, 8'h05);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({phase, freq} !== {8'h40, 12'h3E8}) begin
      bad++; $display("FAIL phase_commit got ph=%h fr=%h want 40 3e8", phase, freq);
    end
    send_pkt(8'h06, 8'h00, 8'h00, 8'h06);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({d, upd, phase, freq} !== {8'h06, 1'b1, 8'h00, 12'd1}) begin
      bad++; $display("FAIL defaults got %02h upd=%b ph=%h fr=%h want 06 1 00 001", d, upd, phase, freq);
    end
    send_pkt(8'h07, 8'h00, 8'h00, 8'h07);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({d, err_cnt} !== {8'h1A, 8'd3}) begin
      bad++; $display("FAIL unknown_op got %02h err=%0d want 1a 3", d, err_cnt);
    end
  endtask

  task automatic test_timeout();
    logic got, upd, va, ua, seen;
    logic [7:0] d;
    seen = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < TO + 5; i++) begin
      tick();
      if (tx_valid) seen = 1'b1;
    end
    total++;
    if ({seen, err_cnt, rx_ready} !== {1'b0, 8'd4, 1'b1}) begin
      bad++; $display("FAIL timeout got vld_seen=%b err=%0d rdy=%b want 0 4 1", seen, err_cnt, rx_ready);
    end
    send_pkt(8'h01, 8'h00, 8'h03, 8'h02);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({got, d, state} !== {1'b1, 8'h06, 5'd0}) begin
      bad++; $display("FAIL post_timeout got=%b %02h st=%0d want 1 06 0", got, d, state);
    end
  endtask

  task automatic test_backpressure_reset();
    logic got, upd, va, ua, held;
    logic [7:0] d;
    tx_ready = 1'b0;
    held = 1'b1;
    send_pkt(8'h03, 8'h00, 8'h05, 8'h06);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = tx_valid;
    end
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(tx_valid === 1'b1 && tx_data === 8'h06 && rx_ready === 1'b0)) held = 1'b0;
    end
    rx_valid = 1'b0;
    total++;
    if ({got, held} !== 2'b11) begin
      bad++; $display("FAIL resp_hold got valid=%b held=%b want 1 1", got, held);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({tx_valid, state, freq, amp, phase, err_cnt} !== {1'b0, 5'd0, 12'd1, 3'd7, 8'd0, 8'd0}) begin
      bad++; $display("FAIL mid_resp_reset got vld=%b cfg=%0d/%h/%0d/%h err=%0d want 0 0/001/7/00 0",
                      tx_valid, state, freq, amp, phase, err_cnt);
    end
    rst_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    send_pkt(8'h05, 8'h00, 8'h00, 8'h05);
    wait_resp(got, d, upd, va, ua);
    total++;
    if ({d, upd, state, amp} !== {8'h06, 1'b1, 5'd0, 3'd7}) begin
      bad++; $display("FAIL shadow_reset got %02h upd=%b st=%0d amp=%0d want 06 1 0 7", d, upd, state, amp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    test_reset();
    test_stage_commit();
    test_nak();
    test_garbage_defaults();
    test_timeout();
    test_backpressure_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
